// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module   : ex_div
// Brief    : Multi-cycle restoring radix-2 divider (DIV/DIVU) for the execute
//            stage; returns {remainder, quotient} and stalls the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module ex_div #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      start_i,
   input  logic                      signed_div_i,
   input  logic [DATA_WIDTH-1:0]     opdata1_i,
   input  logic [DATA_WIDTH-1:0]     opdata2_i,
   input  logic                      annul_i,
   output logic [2*DATA_WIDTH-1:0]   result_o,
   output logic                      ready_o,
   output logic                      stallreq_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] c_last_iter = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CNT_WIDTH-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0]     r_rem;
   logic [DATA_WIDTH-1:0]     r_quo;
   logic [DATA_WIDTH-1:0]     r_divisor;
   logic                      r_neg_quo;
   logic                      r_neg_rem;
   logic [2*DATA_WIDTH-1:0]   r_result;
   logic                      r_ready;

   logic                      w_start;
   logic                      w_last;
   logic                      w_sign1;
   logic                      w_sign2;
   logic [DATA_WIDTH-1:0]     w_mag1;
   logic [DATA_WIDTH-1:0]     w_mag2;
   logic [DATA_WIDTH:0]       w_shift;
   logic                      w_ge;
   logic [DATA_WIDTH-1:0]     w_sub;
   logic [DATA_WIDTH-1:0]     w_rem_nxt;
   logic [DATA_WIDTH-1:0]     w_quo_nxt;
   logic [DATA_WIDTH-1:0]     w_quo_fix;
   logic [DATA_WIDTH-1:0]     w_rem_fix;

   assign w_start = start_i & ~annul_i;
   assign w_last  = (r_cnt == c_last_iter);

   // Magnitudes; the most negative value maps onto itself as an unsigned number.
   assign w_sign1 = signed_div_i & opdata1_i[DATA_WIDTH-1];
   assign w_sign2 = signed_div_i & opdata2_i[DATA_WIDTH-1];
   assign w_mag1  = w_sign1 ? -opdata1_i : opdata1_i;
   assign w_mag2  = w_sign2 ? -opdata2_i : opdata2_i;

   // Partial remainder needs one extra bit after the shift; a successful
   // difference is always below the divisor so it fits back in DATA_WIDTH.
   assign w_shift   = {r_rem, r_quo[DATA_WIDTH-1]};
   assign w_ge      = (w_shift >= {1'b0, r_divisor});
   assign w_sub     = w_shift[DATA_WIDTH-1:0] - r_divisor;
   assign w_rem_nxt = w_ge ? w_sub : w_shift[DATA_WIDTH-1:0];
   assign w_quo_nxt = {r_quo[DATA_WIDTH-2:0], w_ge};

   assign w_quo_fix = r_neg_quo ? -w_quo_nxt : w_quo_nxt;
   assign w_rem_fix = r_neg_rem ? -w_rem_nxt : w_rem_nxt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (annul_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  w_state_nxt = (opdata2_i == '0) ? S_BYZERO : S_ON;
               end
            end
            S_BYZERO: w_state_nxt = S_END;
            S_ON: begin
               if (w_last) begin
                  w_state_nxt = S_END;
               end
            end
            S_END: begin
               if (!start_i) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_neg_quo <= 1'b0;
         r_neg_rem <= 1'b0;
         r_result  <= '0;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_result <= '0;
               r_ready  <= 1'b0;
               r_cnt    <= '0;
               if (w_start) begin
                  r_rem     <= '0;
                  r_quo     <= w_mag1;
                  r_divisor <= w_mag2;
                  r_neg_quo <= w_sign1 ^ w_sign2;
                  r_neg_rem <= w_sign1;
               end
            end
            S_ON: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + c_cnt_one;
               if (w_last) begin
                  r_result <= {w_rem_fix, w_quo_fix};
                  r_ready  <= 1'b1;
               end
            end
            S_BYZERO: begin
               r_result <= '0;
               r_ready  <= 1'b1;
            end
            S_END: begin
               if (!start_i) begin
                  r_result <= '0;
                  r_ready  <= 1'b0;
               end
            end
            default: begin
               r_result <= '0;
               r_ready  <= 1'b0;
            end
         endcase
         // A flush discards whatever the current state would have produced.
         if (annul_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
         end
      end
   end

   assign result_o   = r_result;
   assign ready_o    = r_ready;
   assign stallreq_o = ((r_state == S_IDLE) & w_start) | (r_state == S_ON) |
                       (r_state == S_BYZERO);

endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// Randomized bench for ex_div: behavioural arithmetic model plus directed corner cases.
module tb_ex_div;

   logic        clk;
   logic        resetn;
   logic        start;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        stallreq;

   int          vectors;
   int          miscompares;
   logic [63:0] exp_result;
   bit          exp_valid;

   ex_div #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start_i      (start),
      .signed_div_i (signed_div),
      .opdata1_i    (opdata1),
      .opdata2_i    (opdata2),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready),
      .stallreq_o   (stallreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain language-level division (truncating, remainder takes dividend sign).
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) return 64'd0;
      if (!sg) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Whenever the DUT claims a result, it must be the one the model expects.
   always @(negedge clk) begin
      if (resetn && ready) begin
         check("ready_allowed", {63'd0, ready}, {63'd0, exp_valid});
         if (exp_valid) check("result", result, exp_result);
      end
   end

   task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b,
                                 input logic sg, input logic [63:0] exp);
      int  lat_k;
      bit  seen;
      lat_k = (b == 32'd0) ? 2 : 33;
      @(negedge clk);
      opdata1    = a;
      opdata2    = b;
      signed_div = sg;
      start      = 1'b1;
      exp_result = exp;
      exp_valid  = 1'b1;
      #1 check("stall_on_start", {63'd0, stallreq}, 64'd1);
      seen = 1'b0;
      for (int k = 1; k <= lat_k + 4 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) begin
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = 1'($urandom_range(0, 1));
         end
         if (ready) begin
            seen = 1'b1;
            check("latency", 64'(k), 64'(lat_k));
            check("stall_at_ready", {63'd0, stallreq}, 64'd0);
         end else begin
            check("stall_busy", {63'd0, stallreq}, 64'd1);
         end
      end
      if (!seen) check("ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic finish_op(input int hold);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("ready_held", {63'd0, ready}, 64'd1);
         check("stall_in_end", {63'd0, stallreq}, 64'd0);
      end
      start = 1'b0;
      @(negedge clk);
      check("ready_dropped", {63'd0, ready}, 64'd0);
      check("result_cleared", result, 64'd0);
      check("stall_idle", {63'd0, stallreq}, 64'd0);
      exp_valid = 1'b0;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input int hold, input logic [63:0] exp);
      start_and_wait(a, b, sg, exp);
      finish_op(hold);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic        sg;
      vectors     = 0;
      miscompares = 0;
      exp_valid   = 1'b0;
      exp_result  = 64'd0;
      resetn      = 1'b0;
      start       = 1'b0;
      signed_div  = 1'b0;
      opdata1     = 32'd0;
      opdata2     = 32'd0;
      annul       = 1'b0;

      repeat (2) @(negedge clk);
      check("reset_ready", {63'd0, ready}, 64'd0);
      check("reset_result", result, 64'd0);
      check("reset_stall", {63'd0, stallreq}, 64'd0);
      resetn = 1'b1;

      // Model pinned against hand-computed values.
      check("model_neg7_div2", model(32'hFFFFFFF9, 32'h2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
      check("model_7_divm2", model(32'h7, 32'hFFFFFFFE, 1'b1), {32'h00000001, 32'hFFFFFFFD});
      check("model_overflow", model(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'h0, 32'h80000000});
      check("model_100_div7", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});

      // Directed cases with literal expectations.
      run_op(32'hFFFFFFFF, 32'h10, 1'b0, 0, {32'h0000000F, 32'h0FFFFFFF});
      run_op(32'hFFFFFFF9, 32'h2, 1'b1, 0, {32'hFFFFFFFF, 32'hFFFFFFFD});
      run_op(32'h7, 32'hFFFFFFFE, 1'b1, 1, {32'h00000001, 32'hFFFFFFFD});
      run_op(32'h12345678, 32'h0, 1'b1, 0, 64'd0);
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, {32'h0, 32'h80000000});
      run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 0, {32'h80000000, 32'h0});
      run_op(32'd100, 32'd7, 1'b0, 3, {32'd2, 32'd14});

      // Flush at counter 10 abandons the operation.
      @(negedge clk);
      opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
      repeat (11) @(negedge clk);
      annul = 1'b1; start = 1'b0; exp_valid = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      check("annul_ready", {63'd0, ready}, 64'd0);
      check("annul_stall", {63'd0, stallreq}, 64'd0);
      check("annul_result", result, 64'd0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("annul_no_ready", {63'd0, ready}, 64'd0);
      end
      run_op(32'd100, 32'd7, 1'b0, 0, {32'd2, 32'd14});

      // Flush wins over a simultaneous request in IDLE.
      @(negedge clk);
      opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
      #1 check("annul_prio_stall", {63'd0, stallreq}, 64'd0);
      @(negedge clk);
      check("annul_prio_state", {63'd0, stallreq}, 64'd0);
      check("annul_prio_ready", {63'd0, ready}, 64'd0);
      start = 1'b0; annul = 1'b0;

      // Asynchronous reset during iteration.
      @(negedge clk);
      opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
      repeat (5) @(negedge clk);
      #2 resetn = 1'b0;
      #1 check("rst_on_ready", {63'd0, ready}, 64'd0);
      check("rst_on_result", result, 64'd0);
      start = 1'b0;
      #1 check("rst_on_stall", {63'd0, stallreq}, 64'd0);
      @(negedge clk) resetn = 1'b1;

      // Asynchronous reset while a result is being presented.
      start_and_wait(32'hFFFFFFFF, 32'h10, 1'b0, {32'h0000000F, 32'h0FFFFFFF});
      #2 resetn = 1'b0; exp_valid = 1'b0;
      #1 check("rst_end_ready", {63'd0, ready}, 64'd0);
      check("rst_end_result", result, 64'd0);
      start = 1'b0;
      #1 check("rst_end_stall", {63'd0, stallreq}, 64'd0);
      @(negedge clk) resetn = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {63'd0, ready}, 64'd0);

      // Randomized operations against the model.
      for (int i = 0; i < 40; i++) begin
         a  = $urandom;
         b  = $urandom;
         sg = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: begin b = 32'($urandom_range(1, 15)); b = -b; end
            3: a = 32'h80000000;
            default: ;
         endcase
         run_op(a, b, sg, $urandom_range(0, 2), model(a, b, sg));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
